// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: control/status bundle between the layer sequencer and its datapaths.
// With LAYER_SEQ_PERF_EN defined, the bundle also carries the perf counters.
interface layer_sequencer_if #(
   parameter int NUM_LAYERS = 2,
   parameter int CNT_W = 16,
   parameter int IDX_W = 3
);
   logic start;
   logic stall;
   logic [NUM_LAYERS-1:0] layer_en;
   logic [IDX_W-1:0] layer_idx;
   logic [CNT_W-1:0] step_idx;
   logic step_valid;
   logic first_step;
   logic last_step;
   logic busy;
   logic done;
`ifdef LAYER_SEQ_PERF_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_stalls;
   modport master (input start, stall, output layer_en, layer_idx, step_idx, step_valid,
                   first_step, last_step, busy, done, perf_cycles, perf_stalls);
   modport slave (output start, stall, input layer_en, layer_idx, step_idx, step_valid,
                  first_step, last_step, busy, done, perf_cycles, perf_stalls);
`else
   modport master (input start, stall, output layer_en, layer_idx, step_idx, step_valid,
                   first_step, last_step, busy, done);
   modport slave (output start, stall, input layer_en, layer_idx, step_idx, step_valid,
                  first_step, last_step, busy, done);
`endif
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks NUM_LAYERS layers with one-hot enables, step index and drain gaps.
// Optional LAYER_SEQ_PERF_EN adds saturating busy-cycle and stall counters.
module layer_sequencer #(
   parameter int NUM_LAYERS = 2,
   parameter int CNT_W = 16,
   parameter logic [NUM_LAYERS*CNT_W-1:0] LAYER_LENS = {16'd64, 16'd784},
   parameter int DRAIN_CYCLES = 2,
   parameter int IDX_W = 3
) (
   input logic clk,
   input logic reset,
   layer_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] layer_idx, layer_n;
   logic [CNT_W-1:0] step_idx, step_n, cur_len;
   logic [3:0] drain_cnt, drain_n;
   logic final_q, final_n;
   logic step_valid, at_end, is_last;
   always_comb begin
      cur_len = '0;
      for (int i = 0; i < NUM_LAYERS; i++)
         if (layer_idx == IDX_W'(i)) cur_len = LAYER_LENS[i*CNT_W +: CNT_W];
   end
   assign step_valid = state == RUN && !bus.stall;
   assign at_end = step_valid && step_idx == cur_len - CNT_W'(1);
   assign is_last = layer_idx == IDX_W'(NUM_LAYERS - 1);
   always_comb begin
      state_n = state;
      layer_n = layer_idx;
      step_n = step_idx;
      drain_n = drain_cnt;
      final_n = final_q;
      case (state)
         IDLE: if (bus.start) begin
            state_n = RUN;
            layer_n = '0;
            step_n = '0;
            final_n = 1'b0;
         end
         RUN: if (at_end) begin
            step_n = '0;
            if (DRAIN_CYCLES > 0) begin
               state_n = DRAIN;
               drain_n = '0;
               final_n = is_last;
            end else if (is_last) state_n = DONE;
            else layer_n = layer_idx + IDX_W'(1);
         end else if (step_valid) step_n = step_idx + CNT_W'(1);
         DRAIN: if (drain_cnt == 4'(DRAIN_CYCLES - 1)) begin
            state_n = final_q ? DONE : RUN;
            layer_n = final_q ? layer_idx : layer_idx + IDX_W'(1);
         end else drain_n = drain_cnt + 4'(1);
         DONE: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         layer_idx <= '0;
         step_idx <= '0;
         drain_cnt <= '0;
         final_q <= 1'b0;
      end else begin
         state <= state_n;
         layer_idx <= layer_n;
         step_idx <= step_n;
         drain_cnt <= drain_n;
         final_q <= final_n;
      end
   assign bus.layer_en = state == RUN ? NUM_LAYERS'(1) << layer_idx : '0;
   assign bus.layer_idx = layer_idx;
   assign bus.step_idx = step_idx;
   assign bus.step_valid = step_valid;
   assign bus.first_step = step_valid && step_idx == '0;
   assign bus.last_step = at_end;
   assign bus.busy = state == RUN || state == DRAIN;
   assign bus.done = state == DONE;
`ifdef LAYER_SEQ_PERF_EN
   // counters restart on the IDLE->RUN edge and otherwise hold once the run ends
   always_ff @(posedge clk)
      if (reset || (state == IDLE && bus.start)) begin
         bus.perf_cycles <= '0;
         bus.perf_stalls <= '0;
      end else begin
         if ((state == RUN || state == DRAIN) && bus.perf_cycles != '1)
            bus.perf_cycles <= bus.perf_cycles + 32'd1;
         if (state == RUN && bus.stall && bus.perf_stalls != '1)
            bus.perf_stalls <= bus.perf_stalls + 32'd1;
      end
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of the default two-layer sequencer and a
// three-layer, zero-drain variant against per-cycle expected schedules.
module tb_layer_sequencer;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
   bit sel = 1'b0;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   layer_sequencer_if #(.NUM_LAYERS(2), .CNT_W(16), .IDX_W(3)) b0 ();
   layer_sequencer_if #(.NUM_LAYERS(3), .CNT_W(16), .IDX_W(3)) b1 ();
   assign b0.start = start && !sel;
   assign b0.stall = stall && !sel;
   assign b1.start = start && sel;
   assign b1.stall = stall && sel;
   layer_sequencer u0 (.clk(clk), .reset(reset), .bus(b0));
   layer_sequencer #(.NUM_LAYERS(3), .CNT_W(16), .LAYER_LENS({16'd1, 16'd3, 16'd2}),
                     .DRAIN_CYCLES(0), .IDX_W(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
   logic [7:0] o_en;
   logic [2:0] o_idx;
   logic [15:0] o_step;
   logic o_valid, o_first, o_last, o_busy, o_done;
   assign o_en = sel ? 8'(b1.layer_en) : 8'(b0.layer_en);
   assign o_idx = sel ? b1.layer_idx : b0.layer_idx;
   assign o_step = sel ? b1.step_idx : b0.step_idx;
   assign o_valid = sel ? b1.step_valid : b0.step_valid;
   assign o_first = sel ? b1.first_step : b0.first_step;
   assign o_last = sel ? b1.last_step : b0.last_step;
   assign o_busy = sel ? b1.busy : b0.busy;
   assign o_done = sel ? b1.done : b0.done;
   typedef struct {
      logic stall;
      logic [7:0] en;
      logic [2:0] idx;
      logic [15:0] step;
      logic valid, first, last, busy, done;
   } exp_t;
   exp_t q[$];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // expected per-cycle schedule, one entry per cycle after the start cycle
   task automatic build(input int nl, input int lens[3], input int drain,
                        input int st_step, input int st_len);
      q.delete();
      for (int l = 0; l < nl; l++) begin
         for (int s = 0; s < lens[l]; s++) begin
            if (l == 0 && s == st_step)
               for (int k = 0; k < st_len; k++)
                  q.push_back('{1'b1, 8'(1 << l), 3'(l), 16'(s), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            q.push_back('{1'b0, 8'(1 << l), 3'(l), 16'(s), 1'b1, s == 0, s == lens[l] - 1, 1'b1, 1'b0});
         end
         for (int d = 0; d < drain; d++)
            q.push_back('{1'b0, 8'd0, 3'(l), 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      q.push_back('{1'b0, 8'd0, 3'(nl - 1), 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
   endtask
   // mode 0: single start pulse, 1: start re-pulsed during the run, 2: start held high
   task automatic run(input bit which, input int mode, input int exp_done, input string tag);
      int done_at = -1;
      sel = which;
      @(negedge clk);
      start = 1'b1;
      stall = 1'b0;
      #1;
      chk({tag, " start_busy"}, 32'(o_busy), 0);
      chk({tag, " start_en"}, 32'(o_en), 0);
      foreach (q[i]) begin
         @(negedge clk);
         start = mode == 2 || (mode == 1 && i % 2 == 0);
         stall = q[i].stall;
         #1;
         chk($sformatf("%s[%0d] en", tag, i), 32'(o_en), 32'(q[i].en));
         chk($sformatf("%s[%0d] idx", tag, i), 32'(o_idx), 32'(q[i].idx));
         chk($sformatf("%s[%0d] step", tag, i), 32'(o_step), 32'(q[i].step));
         chk($sformatf("%s[%0d] valid", tag, i), 32'(o_valid), 32'(q[i].valid));
         chk($sformatf("%s[%0d] first", tag, i), 32'(o_first), 32'(q[i].first));
         chk($sformatf("%s[%0d] last", tag, i), 32'(o_last), 32'(q[i].last));
         chk($sformatf("%s[%0d] busy", tag, i), 32'(o_busy), 32'(q[i].busy));
         chk($sformatf("%s[%0d] done", tag, i), 32'(o_done), 32'(q[i].done));
         if (o_done && done_at < 0) done_at = i + 1;
      end
      chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
      @(negedge clk);
      start = mode == 2;
      stall = 1'b0;
      #1;
      chk({tag, " idle_busy"}, 32'(o_busy), 0);
      chk({tag, " idle_done"}, 32'(o_done), 0);
      chk({tag, " idle_en"}, 32'(o_en), 0);
      chk({tag, " idle_idx"}, 32'(o_idx), 32'(q[q.size() - 1].idx));
      if (mode == 2) begin
         @(negedge clk);
         #1;
         chk({tag, " rerun_en"}, 32'(o_en), 1);
         chk({tag, " rerun_step"}, 32'(o_step), 0);
         chk({tag, " rerun_first"}, 32'(o_first), 1);
      end
      start = 1'b0;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_en", 32'(o_en), 0);
         chk("rst_idx", 32'(o_idx), 0);
         chk("rst_step", 32'(o_step), 0);
         chk("rst_busy", 32'(o_busy), 0);
         chk("rst_done", 32'(o_done), 0);
         chk("rst_valid", 32'(o_valid), 0);
      end
      reset = 1'b0;
      build(2, '{784, 64, 0}, 2, -1, 0);
      run(1'b0, 0, 853, "dflt");
`ifdef LAYER_SEQ_PERF_EN
      chk("perf_cycles_dflt", b0.perf_cycles, 852);
      chk("perf_stalls_dflt", b0.perf_stalls, 0);
`endif
      build(2, '{784, 64, 0}, 2, 100, 10);
      run(1'b0, 0, 863, "stall");
`ifdef LAYER_SEQ_PERF_EN
      chk("perf_cycles_stall", b0.perf_cycles, 862);
      chk("perf_stalls_stall", b0.perf_stalls, 10);
`endif
      build(3, '{2, 3, 1}, 0, -1, 0);
      run(1'b1, 0, 7, "three");
      build(2, '{784, 64, 0}, 2, -1, 0);
      run(1'b0, 1, 853, "repulse");
      sel = 1'b0;
      @(negedge clk);
      start = 1'b1;
      #1;
      for (int c = 1; c <= 501; c++) begin
         @(negedge clk);
         start = 1'b0;
         reset = c == 501;
         #1;
      end
      chk("pre_reset_step", 32'(o_step), 500);
      chk("pre_reset_en", 32'(o_en), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_en", 32'(o_en), 0);
      chk("post_reset_busy", 32'(o_busy), 0);
      chk("post_reset_step", 32'(o_step), 0);
      chk("post_reset_done", 32'(o_done), 0);
`ifdef LAYER_SEQ_PERF_EN
      chk("post_reset_perf", b0.perf_cycles, 0);
`endif
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("post_reset_quiet_done", 32'(o_done), 0);
         chk("post_reset_quiet_busy", 32'(o_busy), 0);
      end
      run(1'b0, 0, 853, "restart");
      build(3, '{2, 3, 1}, 0, -1, 0);
      run(1'b1, 2, 7, "held");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("held_reset_busy", 32'(o_busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised successor to the fixed two-layer enable generator for the digit-detection network.
- Steps through NUM_LAYERS layers in order, holding exactly one layer enable high for that layer's programmed number of input steps.
- Inserts a configurable drain gap between layers so the MAC pipeline can flush.
- Sits between the top-level start/result logic and the per-layer datapaths. Also drives the step index used as pixel/weight address.

Parameters:
- NUM_LAYERS, 2, number of layers sequenced (1..8).
- CNT_W, 16, width of the step counter and of each length field.
- LAYER_LENS, {16'd64,16'd784}, packed NUM_LAYERS x CNT_W steps per layer. Layer 0 occupies the LSBs. Each length must be >= 1.
- DRAIN_CYCLES, 2, idle cycles between consecutive layers (0..15). A value of 0 means back-to-back.
- IDX_W, 3, width of layer_idx. Must be >= clog2(NUM_LAYERS), minimum 1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin one inference. Sampled only in IDLE.
- stall, input, 1, freeze the step counter while high (input stream not valid).
- layer_en, output, NUM_LAYERS, one-hot enable of the active layer; all zero outside RUN.
- layer_idx, output, IDX_W, index of the current/last layer.
- step_idx, output, CNT_W, step within the active layer, 0..len-1.
- step_valid, output, 1, high on RUN cycles where stall=0 (the datapath consumes a step).
- first_step, output, 1, step_valid AND step_idx==0 (accumulator clear).
- last_step, output, 1, step_valid AND step_idx==len-1.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, one-cycle pulse after the final layer's drain.

Behaviour:
- Reset values: state=IDLE, layer_en=0, layer_idx=0, step_idx=0, busy=0, done=0. All strobes are 0.
- Reset is synchronous and takes priority over every other input. Reset asserted mid-RUN returns the block to IDLE on the next edge, with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN with layer_idx=0, step_idx=0.
  - start=0 -> stay in IDLE.
- RUN:
  - layer_en[layer_idx]=1.
  - stall=0: step_idx increments each cycle.
  - stall=1: step_idx holds and the strobes are low.
  - On last_step: step_idx->0, then:
    - layer_idx<NUM_LAYERS-1 and DRAIN_CYCLES>0 -> DRAIN.
    - layer_idx<NUM_LAYERS-1 and DRAIN_CYCLES=0 -> stay in RUN, layer_idx+1.
    - layer_idx==NUM_LAYERS-1 and DRAIN_CYCLES>0 -> DRAIN, marked final.
    - layer_idx==NUM_LAYERS-1 and DRAIN_CYCLES=0 -> DONE.
- DRAIN:
  - Layer_en is 0, busy is 1, and stall is ignored.
  - Lasts exactly DRAIN_CYCLES cycles, then:
    - Not final -> RUN, layer_idx+1.
    - Final -> DONE.
- DONE: done=1 for one cycle, busy=0, layer_idx holds the last layer -> IDLE.
- Start behaviour:
  - start asserted outside IDLE is ignored; it is not queued.
  - start held high in IDLE immediately after DONE begins a new inference.
- Latency: a layer of length L with no stalls has layer_en high for exactly L cycles.
  - Total start-to-done = 1 + sum(L) + NUM_LAYERS*DRAIN_CYCLES cycles (the final drain is included when DRAIN_CYCLES>0).
- Length of 1: first_step and last_step assert on the same cycle.
- Counter: step_idx never exceeds len-1 and no wrap past the CNT_W range is possible. Compare against the selected LAYER_LENS slice minus 1.
- layer_en is always one-hot or zero, never multi-hot.

Optional Feature:
- Macro: LAYER_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles, 32 bits, and output perf_stalls, 32 bits.
  - Both clear on the IDLE->RUN transition.
  - perf_cycles counts every busy cycle.
  - perf_stalls counts RUN cycles with stall=1.
  - Both saturate at all-ones and hold their values after done until the next start.
  - Reset clears both.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Defaults, pulse start, stall=0:
  - layer_en=01 for 784 cycles, step_idx 0..783.
  - Then 2 drain cycles, then layer_en=10 for 64 cycles, then 2 drain cycles.
  - done pulses on cycle 853 after start.
- Defaults, stall high for 10 cycles at step 100 of layer 0:
  - step_idx holds 100 and step_valid=0 during the stall.
  - done is delayed by exactly 10 cycles (cycle 863). With perf enabled, perf_stalls=10.
- NUM_LAYERS=3, LAYER_LENS={1,3,2}, DRAIN_CYCLES=0:
  - layer_en sequence 001,001,010,010,010,100.
  - The length-1 layer asserts first_step and last_step together.
  - done occurs on cycle 7.
- Reset asserted at step 500 of layer 0:
  - Next cycle: layer_en=0, busy=0, step_idx=0, no done.
  - A subsequent start restarts at layer 0, step 0.
- start re-pulsed during RUN and DRAIN: ignored and the sequence is unchanged.
- start held high continuously: back-to-back inferences, with exactly one IDLE cycle between done and the next layer_en=01.
